// File: rtl/red_pitaya_na_sweeper.sv
// Network-analyzer sweep initiator: per point writes the frequency, polls the
// IQ block until averaging completes, reads the I/Q sums and emits a result beat.
module red_pitaya_na_sweeper #(
    parameter logic [15:0] FREQ_ADDR   = 16'h0108,
    parameter logic [15:0] STAT_ADDR   = 16'h0140,
    parameter int unsigned POLL_GAP    = 8,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] f_start_i,
    input  logic [31:0] f_step_i,
    input  logic [15:0] n_points_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] addr_o,
    output logic        wen_o,
    output logic        ren_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i,
    input  logic        ack_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [61:0] res_i_o,
    output logic [61:0] res_q_o,
    output logic [15:0] res_idx_o,
    output logic        res_last_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_WRITE, S_POLL, S_GAP,
        S_RD0, S_RD1, S_RD2, S_RD3, S_PUSH
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] gap_q, gap_d;
    logic [31:0] freq_q, freq_d;
    logic [31:0] step_q, step_d;
    logic [15:0] n_q, n_d;
    logic [15:0] idx_q, idx_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic [61:0] res_i_q, res_i_d;
    logic [61:0] res_q_q, res_q_d;

    logic        bus_st;
    logic        bus_wr;
    logic [15:0] bus_addr;
    logic        acked;
    logic        last;

    assign last = (idx_q == n_q - 16'd1);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        freq_d   = freq_q;
        step_d   = step_q;
        n_d      = n_q;
        idx_d    = idx_q;
        err_d    = err_q;
        done_d   = 1'b0;
        res_i_d  = res_i_q;
        res_q_d  = res_q_q;
        bus_st   = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = '0;

        unique case (state_q)
            S_WRITE: begin
                bus_st   = 1'b1;
                bus_wr   = 1'b1;
                bus_addr = FREQ_ADDR;
            end
            S_POLL, S_RD0: begin
                bus_st   = 1'b1;
                bus_addr = STAT_ADDR;
            end
            S_RD1: begin
                bus_st   = 1'b1;
                bus_addr = STAT_ADDR + 16'h4;
            end
            S_RD2: begin
                bus_st   = 1'b1;
                bus_addr = STAT_ADDR + 16'h8;
            end
            S_RD3: begin
                bus_st   = 1'b1;
                bus_addr = STAT_ADDR + 16'hC;
            end
            default: ;
        endcase

        // Strobe only on the first cycle of a bus state; address/data persist
        // for as long as the state does.
        wen_o   = bus_st && bus_wr && !pend_q;
        ren_o   = bus_st && !bus_wr && !pend_q;
        addr_o  = bus_addr;
        wdata_o = bus_wr ? freq_q : '0;
        acked   = bus_st && pend_q && ack_i;

        if (bus_st && !pend_q) begin
            pend_d = 1'b1;
            tmo_d  = '0;
        end else if (bus_st && !ack_i) begin
            tmo_d = tmo_q + 16'd1;
        end
        if (acked) pend_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (n_points_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        freq_d  = f_start_i;
                        step_d  = f_step_i;
                        n_d     = n_points_i;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: if (acked) state_d = S_POLL;
            S_POLL: begin
                if (acked) begin
                    if (!rdata_i[31]) begin
                        state_d = S_RD0;
                    end else if (POLL_GAP == 0) begin
                        state_d = S_POLL;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == GAP_LAST) state_d = S_POLL;
            end
            S_RD0: if (acked) begin
                res_i_d[30:0] = rdata_i[30:0];
                state_d       = S_RD1;
            end
            S_RD1: if (acked) begin
                res_i_d[61:31] = rdata_i[30:0];
                state_d        = S_RD2;
            end
            S_RD2: if (acked) begin
                res_q_d[30:0] = rdata_i[30:0];
                state_d       = S_RD3;
            end
            S_RD3: if (acked) begin
                res_q_d[61:31] = rdata_i[30:0];
                state_d        = S_PUSH;
            end
            S_PUSH: begin
                if (res_ready_i) begin
                    idx_d  = idx_q + 16'd1;
                    freq_d = freq_q + step_q;
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus_st && pend_q && !ack_i && tmo_q == TMO_LAST) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
            err_d   = 1'b1;
        end

        // Abort wins over start, ack and timeout; the error flag is left alone.
        if (abort_i) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
            err_d   = err_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            tmo_q   <= '0;
            gap_q   <= '0;
            freq_q  <= '0;
            step_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            res_i_q <= '0;
            res_q_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            freq_q  <= freq_d;
            step_q  <= step_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            done_q  <= done_d;
            res_i_q <= res_i_d;
            res_q_q <= res_q_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign res_valid_o = (state_q == S_PUSH);
    assign res_last_o  = (state_q == S_PUSH) && last;
    assign res_idx_o   = idx_q;
    assign res_i_o     = res_i_q;
    assign res_q_o     = res_q_q;

endmodule
